// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the MEM stage (priority) and an external valid/ready master.
// Latency: CPU reads are combinational; CPU/external writes commit at the grant edge; external read data is registered (1 cycle).
// Backpressure: external requests wait while the CPU accesses, but are force-granted after MAX_WAIT denied cycles (CPU stalls 1 cycle).
module dmem_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // MEM-stage port
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [XLEN/8-1:0]     cpu_be,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [XLEN-1:0]       cpu_wd,
  output logic [XLEN-1:0]       cpu_rd,
  output logic                  cpu_stall,
  // external master port
  input  logic                  ext_valid,
  output logic                  ext_ready,
  input  logic                  ext_we,
  input  logic [XLEN/8-1:0]     ext_be,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [XLEN-1:0]       ext_wd,
  output logic                  ext_rvalid,
  output logic [XLEN-1:0]       ext_rdata,
  // memory port
  output logic                  mem_we,
  output logic [XLEN/8-1:0]     mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wd,
  input  logic [XLEN-1:0]       mem_rd
);

  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic            ext_rvalid_q, ext_rvalid_d;
  logic [XLEN-1:0] ext_rdata_q;

  logic force_grant;
  logic grant_ext;
  logic grant_cpu;

  // Grant decision: CPU wins unless the external master has waited MAX_WAIT cycles
  always_comb begin
    force_grant = ext_valid && (wait_cnt_q >= 4'(MAX_WAIT));
    grant_ext   = ext_valid && (!cpu_req || force_grant);
    grant_cpu   = cpu_req && !grant_ext;
  end

  // Memory port mux; with no grant the CPU fields pass through but writes are blocked
  always_comb begin
    if (grant_ext) begin
      mem_we   = ext_we;
      mem_be   = ext_be;
      mem_addr = ext_addr;
      mem_wd   = ext_wd;
    end else begin
      mem_we   = cpu_we && grant_cpu;
      mem_be   = cpu_be;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end
  end

  // Next-state for the starvation counter and the read-response flag
  always_comb begin
    if (grant_ext || !ext_valid) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != 4'd15) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    ext_rvalid_d = grant_ext && !ext_we;
  end

  // State registers; response data only updates when a read was granted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q   <= 4'd0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
      if (ext_rvalid_d) begin
        ext_rdata_q <= mem_rd;
      end
    end
  end

  assign cpu_rd     = mem_rd;
  assign cpu_stall  = cpu_req && grant_ext;
  assign ext_ready  = grant_ext;
  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: outputs sampled at the falling edge; model advances at each rising edge.
// Backpressure: stimulus obeys the hold-until-ready and stalled-CPU-repeats rules.
module tb_dmem_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [3:0]  cpu_be = 4'd0;
  logic [7:0]  cpu_addr = 8'd0;
  logic [31:0] cpu_wd = 32'd0;
  logic        ext_valid = 1'b0, ext_we = 1'b0;
  logic [3:0]  ext_be = 4'd0;
  logic [7:0]  ext_addr = 8'd0;
  logic [31:0] ext_wd = 32'd0;
  wire  [31:0] cpu_rd, ext_rdata, mem_wd, mem_rd;
  wire         cpu_stall, ext_ready, ext_rvalid, mem_we;
  wire  [3:0]  mem_be;
  wire  [7:0]  mem_addr;

  always #5 clk = ~clk;

  dmem_arbiter #(.XLEN(32), .ADDR_WIDTH(8), .MAX_WAIT(MW)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_we(ext_we), .ext_be(ext_be),
    .ext_addr(ext_addr), .ext_wd(ext_wd), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Second instance with the largest wait bound, used for the long-wait scenario
  logic        s_creq = 1'b0, s_ev = 1'b0;
  logic        s_zero1 = 1'b0;
  logic [3:0]  s_zero4 = 4'd0;
  logic [7:0]  s_zero8 = 8'd0;
  logic [31:0] s_zero32 = 32'd0;
  wire  [31:0] s_cpu_rd, s_ext_rdata, s_mem_wd;
  wire         s_cpu_stall, s_ext_ready, s_ext_rvalid, s_mem_we;
  wire  [3:0]  s_mem_be;
  wire  [7:0]  s_mem_addr;

  dmem_arbiter #(.XLEN(32), .ADDR_WIDTH(8), .MAX_WAIT(15)) u_sat (
    .clk(clk), .reset(reset),
    .cpu_req(s_creq), .cpu_we(s_zero1), .cpu_be(s_zero4), .cpu_addr(s_zero8),
    .cpu_wd(s_zero32), .cpu_rd(s_cpu_rd), .cpu_stall(s_cpu_stall),
    .ext_valid(s_ev), .ext_ready(s_ext_ready), .ext_we(s_zero1), .ext_be(s_zero4),
    .ext_addr(s_zero8), .ext_wd(s_zero32), .ext_rvalid(s_ext_rvalid), .ext_rdata(s_ext_rdata),
    .mem_we(s_mem_we), .mem_be(s_mem_be), .mem_addr(s_mem_addr), .mem_wd(s_mem_wd), .mem_rd(s_zero32)
  );

  // Memory fixture driven purely by the DUT memory port
  logic [31:0] fmem [256];
  logic        clr_mem = 1'b1;
  assign mem_rd = fmem[mem_addr];

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 256; i++) fmem[i] <= 32'd0;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) fmem[mem_addr][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  int          streak;
  logic        exp_rv;
  logic [31:0] exp_rd;
  int          s_streak;

  // Observations from the most recent tick
  logic        last_ge, last_stall, last_rdy, last_rv;
  logic [31:0] last_cpu_rd, last_rdata;
  logic        s_last_rdy;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle on the main instance: check at the falling edge, advance the model at the rising edge
  task automatic tick(input bit rst_mid);
    bit         ge, we;
    logic [7:0] a;
    @(negedge clk);
    ge = ext_valid && (!cpu_req || streak >= MW);
    a  = ge ? ext_addr : cpu_addr;
    we = ge ? ext_we : (cpu_req && cpu_we);
    chk("ext_ready", ext_ready, ge);
    chk("cpu_stall", cpu_stall, cpu_req && ge);
    chk("mem_we", mem_we, we);
    chk("mem_addr", mem_addr, a);
    chk("mem_be", mem_be, ge ? ext_be : cpu_be);
    chk("mem_wd", mem_wd, ge ? ext_wd : cpu_wd);
    chk("cpu_rd", cpu_rd, ref_mem[a]);
    chk("ext_rvalid", ext_rvalid, exp_rv);
    chk("ext_rdata", ext_rdata, exp_rd);
    last_ge = ge; last_stall = cpu_stall; last_rdy = ext_ready;
    last_rv = ext_rvalid; last_rdata = ext_rdata; last_cpu_rd = cpu_rd;
    if (rst_mid) reset = 1'b1;
    @(posedge clk);
    if (reset) begin
      streak = 0; exp_rv = 1'b0; exp_rd = 32'd0;
    end else begin
      exp_rv = ge && !ext_we;
      if (exp_rv) exp_rd = ref_mem[a];
      if (ge || !ext_valid) streak = 0;
      else if (streak < 15) streak++;
    end
    if (we)
      for (int b = 0; b < 4; b++)
        if ((ge ? ext_be[b] : cpu_be[b])) ref_mem[a][8*b +: 8] = (ge ? ext_wd[8*b +: 8] : cpu_wd[8*b +: 8]);
    #1;
  endtask

  // One cycle on the long-wait instance (CPU requests continuously)
  task automatic sat_tick();
    bit sg;
    @(negedge clk);
    sg = s_ev && (!s_creq || s_streak >= 15);
    chk("sat_ready", s_ext_ready, sg);
    chk("sat_stall", s_cpu_stall, s_creq && sg);
    s_last_rdy = s_ext_ready;
    @(posedge clk);
    if (reset || sg || !s_ev) s_streak = 0;
    else if (s_streak < 15) s_streak++;
    #1;
  endtask

  initial begin
    int first;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    streak = 0; exp_rv = 1'b0; exp_rd = 32'd0; s_streak = 0;
    @(posedge clk); #1;
    clr_mem = 1'b0;

    // Reset and idle
    tick(0); tick(0);
    chk("rst_rvalid", last_rv, 1'b0);
    chk("rst_rdata", last_rdata, 32'd0);
    chk("rst_stall", last_stall, 1'b0);
    chk("rst_ready", last_rdy, 1'b0);
    reset = 1'b0;
    tick(0);

    // CPU store then load
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_be = 4'hF; cpu_wd = 32'hDEADBEEF;
    tick(0);
    chk("cpu_st_stall", last_stall, 1'b0);
    cpu_we = 0; cpu_wd = 32'd0;
    tick(0);
    chk("cpu_ld_data", last_cpu_rd, 32'hDEADBEEF);
    chk("cpu_ld_stall", last_stall, 1'b0);
    cpu_req = 0;

    // External partial write then read
    ext_valid = 1; ext_we = 1; ext_addr = 8'h20; ext_be = 4'b0011; ext_wd = 32'h12345678;
    tick(0);
    chk("ext_wr_ready", last_rdy, 1'b1);
    ext_we = 0;
    tick(0);
    chk("ext_rd_ready", last_rdy, 1'b1);
    ext_valid = 0;
    tick(0);
    chk("ext_rd_rvalid", last_rv, 1'b1);
    chk("ext_rd_data", last_rdata, 32'h00005678);
    tick(0);
    chk("ext_rd_pulse", last_rv, 1'b0);
    chk("ext_rd_hold", last_rdata, 32'h00005678);

    // Contention: both request continuously from cycle 0
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h04;
    ext_valid = 1; ext_we = 0; ext_addr = 8'h10;
    for (int k = 0; k < 6; k++) begin
      tick(0);
      chk("cont_ready", last_rdy, (k == 4));
      chk("cont_stall", last_stall, (k == 4));
    end
    ext_valid = 0; cpu_req = 0;
    tick(0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if (!(ext_valid && !last_ge)) begin
        ext_valid = ($urandom_range(0, 9) < 6);
        ext_we    = $urandom_range(0, 1);
        ext_be    = 4'($urandom);
        ext_addr  = 8'($urandom_range(0, 15));
        ext_wd    = $urandom;
      end
      if (!(cpu_req && last_stall)) begin
        cpu_req  = ($urandom_range(0, 9) < 7);
        cpu_we   = $urandom_range(0, 1);
        cpu_be   = 4'($urandom);
        cpu_addr = 8'($urandom_range(0, 15));
        cpu_wd   = $urandom;
      end
      tick(0);
    end
    ext_valid = 0; cpu_req = 0;
    tick(0);

    // Reset arriving while a read response is pending
    ext_valid = 1; ext_we = 0; ext_addr = 8'h20;
    tick(1);
    chk("rstmid_ready", last_rdy, 1'b1);
    ext_valid = 0;
    tick(0);
    chk("rstmid_rvalid", last_rv, 1'b0);
    chk("rstmid_rdata", last_rdata, 32'd0);
    reset = 1'b0;
    tick(0);
    chk("rstmid_rvalid2", last_rv, 1'b0);
    chk("rstmid_rdata2", last_rdata, 32'd0);

    // Long wait bound: grant after 15 denials; dropping valid restarts the count
    s_creq = 1; s_ev = 1; first = -1;
    for (int k = 0; k < 17; k++) begin
      sat_tick();
      if (s_last_rdy && first < 0) first = k;
    end
    chk("sat_first_grant", first, 15);
    for (int k = 0; k < 5; k++) sat_tick();
    s_ev = 0;
    sat_tick();
    s_ev = 1; first = -1;
    for (int k = 0; k < 17; k++) begin
      sat_tick();
      if (s_last_rdy && first < 0) first = k;
    end
    chk("sat_restart_grant", first, 15);
    s_ev = 0; s_creq = 0;
    sat_tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
